// File: rtl/mem_access_pkg.sv
// Shared defines for the MEM-stage data-bus master: ALUOp codes, bus size and FSM state encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_access_pkg;

    // Memory ALUOp codes (8-bit shared ALUOp bus)
    localparam logic [7:0] OP_LB   = 8'h30;
    localparam logic [7:0] OP_LBU  = 8'h31;
    localparam logic [7:0] OP_LH   = 8'h32;
    localparam logic [7:0] OP_LHU  = 8'h33;
    localparam logic [7:0] OP_LW   = 8'h34;
    localparam logic [7:0] OP_LL   = 8'h35;
    localparam logic [7:0] OP_LWL  = 8'h36;
    localparam logic [7:0] OP_LWR  = 8'h37;
    localparam logic [7:0] OP_SB   = 8'h38;
    localparam logic [7:0] OP_SH   = 8'h39;
    localparam logic [7:0] OP_SW   = 8'h3A;
    localparam logic [7:0] OP_SC   = 8'h3B;
    localparam logic [7:0] OP_SWL  = 8'h3C;
    localparam logic [7:0] OP_SWR  = 8'h3D;
    localparam logic [7:0] OP_ADDU = 8'h01;

    // bus_size encoding
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_RESP  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

endpackage

// File: rtl/mem_access_store_align.sv
// Decodes a memory op into bus size, aligned address, byte enables, lane-aligned store data and alignment fault.
// Latency: purely combinational.
// Backpressure: none; inputs are expected to be held by the caller while stalled.
module mem_store_align
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ALUOP_W = 8
) (
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [ADDR_W-1:0]  vaddr,
    input  logic [31:0]        st_data,
    output logic               is_load,
    output logic               is_store,
    output logic               is_sc,
    output logic               fault,
    output logic [1:0]         size,
    output logic [ADDR_W-1:0]  addr,
    output logic [3:0]         wen,
    output logic [31:0]        wdata
);

    logic [1:0]        a;
    logic [ADDR_W-1:0] word_addr;

    assign a         = vaddr[1:0];
    assign word_addr = {vaddr[ADDR_W-1:2], 2'b00};

    // Per-op decode; unaligned-word ops (LWL/LWR/SWL/SWR) never fault
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_sc    = 1'b0;
        fault    = 1'b0;
        size     = SZ_WORD;
        addr     = word_addr;
        wen      = 4'b0000;
        wdata    = 32'h0;
        case (aluop)
            ALUOP_W'(OP_LB), ALUOP_W'(OP_LBU): begin
                is_load = 1'b1;
                size    = SZ_BYTE;
                addr    = vaddr;
            end
            ALUOP_W'(OP_LH), ALUOP_W'(OP_LHU): begin
                is_load = 1'b1;
                size    = SZ_HALF;
                addr    = vaddr;
                fault   = a[0];
            end
            ALUOP_W'(OP_LW), ALUOP_W'(OP_LL): begin
                is_load = 1'b1;
                fault   = (a != 2'b00);
            end
            ALUOP_W'(OP_LWL), ALUOP_W'(OP_LWR): begin
                is_load = 1'b1;
            end
            ALUOP_W'(OP_SB): begin
                is_store = 1'b1;
                size     = SZ_BYTE;
                addr     = vaddr;
                wen      = 4'b0001 << a;
                wdata    = {4{st_data[7:0]}};
            end
            ALUOP_W'(OP_SH): begin
                is_store = 1'b1;
                size     = SZ_HALF;
                addr     = vaddr;
                fault    = a[0];
                wen      = a[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{st_data[15:0]}};
            end
            ALUOP_W'(OP_SW), ALUOP_W'(OP_SC): begin
                is_store = 1'b1;
                is_sc    = (aluop == ALUOP_W'(OP_SC));
                fault    = (a != 2'b00);
                wen      = 4'b1111;
                wdata    = st_data;
            end
            ALUOP_W'(OP_SWL): begin
                is_store = 1'b1;
                wen      = 4'b1111 >> (2'd3 - a);
                wdata    = st_data >> {2'd3 - a, 3'b000};
            end
            ALUOP_W'(OP_SWR): begin
                is_store = 1'b1;
                wen      = 4'b1111 << a;
                wdata    = st_data << {a, 3'b000};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-bus master: issues one aligned request per load/store and registers the result for WriteBack.
// Latency: op at cycle 0, bus_en at cycle 1, DONE at cycle 2 on a zero-wait bus.
// Backpressure: stallreq holds the pipeline until data_ok; DONE holds results until adv.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ALUOP_W = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               op_valid,
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [ADDR_W-1:0]  vaddr,
    input  logic [31:0]        st_data,
    input  logic               llbit,
    input  logic               flush,
    input  logic               adv,
    output logic               bus_en,
    output logic [3:0]         bus_wen,
    output logic [1:0]         bus_size,
    output logic [ADDR_W-1:0]  bus_addr,
    output logic [31:0]        bus_wdata,
    input  logic               bus_addr_ok,
    input  logic               bus_data_ok,
    input  logic [31:0]        bus_rdata,
    output logic [31:0]        m_rdata,
    output logic [ADDR_W-1:0]  m_vaddr,
    output logic               adel,
    output logic               ades,
    output logic               stallreq
);

    logic [2:0]        state_q, state_d;
    logic [3:0]        wen_q, wen_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       m_rdata_q, m_rdata_d;
    logic [ADDR_W-1:0] m_vaddr_q, m_vaddr_d;

    logic              is_load, is_store, is_sc, fault;
    logic [1:0]        dec_size;
    logic [ADDR_W-1:0] dec_addr;
    logic [3:0]        dec_wen;
    logic [31:0]       dec_wdata;
    logic              start;
    logic [31:0]       resp_word;

    mem_store_align #(
        .ADDR_W  (ADDR_W),
        .ALUOP_W (ALUOP_W)
    ) u_align (
        .aluop    (aluop),
        .vaddr    (vaddr),
        .st_data  (st_data),
        .is_load  (is_load),
        .is_store (is_store),
        .is_sc    (is_sc),
        .fault    (fault),
        .size     (dec_size),
        .addr     (dec_addr),
        .wen      (dec_wen),
        .wdata    (dec_wdata)
    );

    assign start = (state_q == ST_IDLE) & op_valid & (is_load | is_store) & ~fault & ~flush;

    // A load leaves wen all-zero, so the latched wen tells loads from stores at response time
    assign resp_word = (wen_q == 4'b0000) ? bus_rdata : 32'h0;

    // Next-state: single outstanding request; flushes after acceptance must drain the response
    always_comb begin
        state_d   = state_q;
        wen_d     = wen_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        m_rdata_d = m_rdata_q;
        m_vaddr_d = m_vaddr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_sc && !llbit) begin
                        // Failed SC: no bus access, result word is zero
                        state_d   = ST_DONE;
                        m_rdata_d = 32'h0;
                        m_vaddr_d = vaddr;
                    end else begin
                        state_d = ST_REQ;
                        wen_d   = dec_wen;
                        size_d  = dec_size;
                        addr_d  = dec_addr;
                        wdata_d = dec_wdata;
                    end
                end
            end
            ST_REQ: begin
                if (flush) begin
                    state_d = (bus_addr_ok && !bus_data_ok) ? ST_DRAIN : ST_IDLE;
                end else if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        state_d   = ST_DONE;
                        m_rdata_d = resp_word;
                        m_vaddr_d = vaddr;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bus_data_ok) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DONE;
                        m_rdata_d = resp_word;
                        m_vaddr_d = vaddr;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (flush || adv) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus_data_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            wen_q     <= 4'b0000;
            size_q    <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            m_rdata_q <= 32'h0;
            m_vaddr_q <= '0;
        end else begin
            state_q   <= state_d;
            wen_q     <= wen_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            m_rdata_q <= m_rdata_d;
            m_vaddr_q <= m_vaddr_d;
        end
    end

    assign bus_en    = (state_q == ST_REQ);
    assign bus_wen   = wen_q;
    assign bus_size  = size_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign m_rdata   = m_rdata_q;
    assign m_vaddr   = m_vaddr_q;
    assign adel      = op_valid & is_load & fault;
    assign ades      = op_valid & is_store & fault;
    assign stallreq  = start | (state_q == ST_REQ) | (state_q == ST_RESP) | (state_q == ST_DRAIN);

endmodule

// File: tb/tb_mem_access.sv
// Scenario bench for mem_access with a byte-lane reference model and a scripted bus slave.
// Latency: n/a.
// Backpressure: bench drives addr_ok/data_ok wait states and adv delays.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk, resetn, op_valid, llbit, flush, adv;
    logic [7:0]  aluop;
    logic [31:0] vaddr, st_data;
    logic        bus_en, bus_addr_ok, bus_data_ok;
    logic [3:0]  bus_wen;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [31:0] m_rdata, m_vaddr;
    logic        adel, ades, stallreq;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl_rdata, mdl_vaddr;

    typedef struct packed {
        logic        is_mem;
        logic        is_load;
        logic        is_store;
        logic        is_sc;
        logic        fault;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } exp_t;

    mem_access #(.ADDR_W(32), .ALUOP_W(8)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .aluop(aluop), .vaddr(vaddr),
        .st_data(st_data), .llbit(llbit), .flush(flush), .adv(adv),
        .bus_en(bus_en), .bus_wen(bus_wen), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .m_rdata(m_rdata), .m_vaddr(m_vaddr),
        .adel(adel), .ades(ades), .stallreq(stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: access width in bytes, which byte lanes are written and which source byte lands in each
    function automatic exp_t model(input logic [7:0] op, input logic [31:0] va, input logic [31:0] sd);
        exp_t e;
        int   nb;
        int   a;
        bit   partial;
        e  = '0;
        nb = 0;
        a  = int'(va[1:0]);
        case (op)
            OP_LB, OP_LBU:                begin e.is_load = 1; nb = 1; end
            OP_LH, OP_LHU:                begin e.is_load = 1; nb = 2; end
            OP_LW, OP_LL, OP_LWL, OP_LWR: begin e.is_load = 1; nb = 4; end
            OP_SB:                        begin e.is_store = 1; nb = 1; end
            OP_SH:                        begin e.is_store = 1; nb = 2; end
            OP_SW, OP_SC, OP_SWL, OP_SWR: begin e.is_store = 1; nb = 4; end
            default: ;
        endcase
        partial  = (op == OP_LWL) || (op == OP_LWR) || (op == OP_SWL) || (op == OP_SWR);
        e.is_mem = e.is_load | e.is_store;
        e.is_sc  = (op == OP_SC);
        if (e.is_mem && !partial) e.fault = ((va % nb) != 0);
        e.size = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
        e.addr = (nb == 4) ? (va & 32'hFFFF_FFFC) : va;
        if (e.is_store) begin
            for (int i = 0; i < 4; i++) begin
                int src;
                bit en;
                if (op == OP_SWL)      begin en = (i <= a); src = 3 - a + i; end
                else if (op == OP_SWR) begin en = (i >= a); src = i - a; end
                else                   begin en = (i >= a) && (i < a + nb); src = i % nb; end
                e.wen[i] = en;
                if (en || !partial) e.wdata[8*i +: 8] = sd[8*src +: 8];
            end
        end
        return e;
    endfunction

    task automatic idle_inputs();
        op_valid = 0; aluop = OP_ADDU; vaddr = 0; st_data = 0; llbit = 0;
        flush = 0; adv = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    endtask

    // One op through the stage: aw addr wait cycles, dw cycles from accept to data_ok, hold DONE cycles without adv
    task automatic do_op(input logic [7:0] op, input logic [31:0] va, input logic [31:0] sd, input logic ll,
                         input int aw, input int dw, input logic [31:0] rd, input int hold);
        exp_t e;
        e = model(op, va, sd);
        @(negedge clk);
        bus_addr_ok = 0; bus_data_ok = 0; flush = 0; adv = 0;
        op_valid = 1; aluop = op; vaddr = va; st_data = sd; llbit = ll;
        #1;
        checks++;
        if ({adel, ades} !== {e.is_load & e.fault, e.is_store & e.fault})
            $display("FAIL addr_err op=%h va=%h got adel/ades=%b%b want %b%b", op, va, adel, ades,
                     e.is_load & e.fault, e.is_store & e.fault);
        if ({adel, ades} !== {e.is_load & e.fault, e.is_store & e.fault}) errors++;
        if (!e.is_mem || e.fault) begin
            checks++;
            if (stallreq !== 1'b0) begin
                errors++; $display("FAIL nostart_stall op=%h va=%h got %b want 0", op, va, stallreq);
            end
            @(negedge clk); #1;
            checks++;
            if ({bus_en, stallreq} !== 2'b00) begin
                errors++; $display("FAIL nostart_bus op=%h va=%h got en/stall=%b%b want 00", op, va, bus_en, stallreq);
            end
            op_valid = 0;
            return;
        end
        checks++;
        if (stallreq !== 1'b1) begin
            errors++; $display("FAIL start_stall op=%h va=%h got %b want 1", op, va, stallreq);
        end
        if (e.is_sc && !ll) begin
            mdl_rdata = 32'h0; mdl_vaddr = va;
        end else begin
            for (int c = 0; c <= aw; c++) begin
                @(negedge clk); bus_addr_ok = 0; bus_data_ok = 0; #1;
                checks++;
                if ({bus_en, bus_addr, bus_size, bus_wen, bus_wdata, stallreq} !==
                    {1'b1, e.addr, e.size, e.wen, e.wdata, 1'b1}) begin
                    errors++;
                    $display("FAIL req op=%h va=%h cyc=%0d got en=%b addr=%h size=%0d wen=%b wdata=%h stall=%b want en=1 addr=%h size=%0d wen=%b wdata=%h stall=1",
                             op, va, c, bus_en, bus_addr, bus_size, bus_wen, bus_wdata, stallreq,
                             e.addr, e.size, e.wen, e.wdata);
                end
                if (c == aw) begin bus_addr_ok = 1; bus_data_ok = (dw == 0); bus_rdata = rd; end
            end
            for (int k = 1; k <= dw; k++) begin
                @(negedge clk); bus_addr_ok = 0; bus_data_ok = 0; #1;
                checks++;
                if ({bus_en, stallreq, m_rdata} !== {1'b0, 1'b1, mdl_rdata}) begin
                    errors++;
                    $display("FAIL resp_wait op=%h k=%0d got en=%b stall=%b m_rdata=%h want en=0 stall=1 m_rdata=%h",
                             op, k, bus_en, stallreq, m_rdata, mdl_rdata);
                end
                if (k == dw) begin bus_data_ok = 1; bus_rdata = rd; end
            end
            mdl_rdata = e.is_load ? rd : 32'h0;
            mdl_vaddr = va;
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk); bus_addr_ok = 0; bus_data_ok = 0; adv = 0; #1;
            checks++;
            if ({bus_en, stallreq, m_rdata, m_vaddr} !== {1'b0, 1'b0, mdl_rdata, mdl_vaddr}) begin
                errors++;
                $display("FAIL done op=%h h=%0d got en=%b stall=%b m_rdata=%h m_vaddr=%h want en=0 stall=0 m_rdata=%h m_vaddr=%h",
                         op, h, bus_en, stallreq, m_rdata, m_vaddr, mdl_rdata, mdl_vaddr);
            end
            if (h == hold) adv = 1;
        end
        @(negedge clk); adv = 0; op_valid = 0; #1;
        checks++;
        if ({bus_en, stallreq} !== 2'b00) begin
            errors++; $display("FAIL after_adv op=%h got en/stall=%b%b want 00", op, bus_en, stallreq);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({bus_en, bus_wen, bus_size, bus_addr, bus_wdata, m_rdata, m_vaddr, adel, ades, stallreq} !== '0) begin
            errors++;
            $display("FAIL %s got en=%b wen=%b size=%0d addr=%h wdata=%h m_rdata=%h m_vaddr=%h adel=%b ades=%b stall=%b want all 0",
                     tag, bus_en, bus_wen, bus_size, bus_addr, bus_wdata, m_rdata, m_vaddr, adel, ades, stallreq);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset_state");
        @(negedge clk); resetn = 1;
        mdl_rdata = 0; mdl_vaddr = 0;
    endtask

    task automatic test_load_basic();
        do_op(OP_LB, 32'h0000_1003, $urandom, 0, 0, 0, 32'h80AA_55CC, 0);
        checks++;
        if ({m_rdata, m_vaddr} !== {32'h80AA_55CC, 32'h0000_1003}) begin
            errors++; $display("FAIL lb_result got %h/%h want 80aa55cc/00001003", m_rdata, m_vaddr);
        end
    endtask

    task automatic test_store_align();
        do_op(OP_SWR, 32'h0000_2002, 32'h1122_3344, 0, 0, 0, $urandom, 0);
        do_op(OP_SWL, 32'h0000_2001, 32'h1122_3344, 0, 0, 1, $urandom, 0);
        do_op(OP_SB,  32'h0000_2003, 32'hA5A5_A5F0, 0, 1, 0, $urandom, 0);
        do_op(OP_SH,  32'h0000_2002, 32'h0000_BEEF, 0, 0, 0, $urandom, 0);
    endtask

    task automatic test_misalign();
        do_op(OP_LW, 32'h0000_3002, 0, 0, 0, 0, 0, 0);
        do_op(OP_SH, 32'h0000_3001, 32'h1234, 0, 0, 0, 0, 0);
        do_op(OP_SC, 32'h0000_3003, 32'h1234, 1, 0, 0, 0, 0);
    endtask

    task automatic test_latency();
        do_op(OP_LW, 32'h0000_4000, 0, 0, 3, 2, 32'hCAFE_F00D, 2);
    endtask

    task automatic test_flush_req();
        @(negedge clk);
        op_valid = 1; aluop = OP_SW; vaddr = 32'h0000_7000; st_data = 32'h5555_AAAA; flush = 0; adv = 0;
        @(negedge clk); flush = 1; bus_addr_ok = 0;
        @(negedge clk); flush = 0; op_valid = 0; #1;
        checks++;
        if ({bus_en, stallreq} !== 2'b00) begin
            errors++; $display("FAIL flush_req got en/stall=%b%b want 00", bus_en, stallreq);
        end
    endtask

    task automatic test_flush_drain();
        logic [31:0] va1, va2, rd2;
        va1 = $urandom & 32'hFFFF_FFFC;
        va2 = $urandom & 32'hFFFF_FFFC;
        rd2 = $urandom;
        @(negedge clk);
        op_valid = 1; aluop = OP_LW; vaddr = va1; flush = 0; adv = 0;
        @(negedge clk); #1;
        checks++;
        if ({bus_en, bus_addr} !== {1'b1, va1}) begin
            errors++; $display("FAIL drain_req1 got en=%b addr=%h want 1 %h", bus_en, bus_addr, va1);
        end
        bus_addr_ok = 1; bus_data_ok = 0;
        @(negedge clk); bus_addr_ok = 0; flush = 1; #1;
        checks++;
        if (stallreq !== 1'b1) begin
            errors++; $display("FAIL drain_resp_stall got %b want 1", stallreq);
        end
        @(negedge clk); flush = 0; op_valid = 1; aluop = OP_LW; vaddr = va2;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            bus_data_ok = 0; #1;
            checks++;
            if ({bus_en, stallreq, m_rdata} !== {1'b0, 1'b1, mdl_rdata}) begin
                errors++;
                $display("FAIL drain_wait k=%0d got en=%b stall=%b m_rdata=%h want 0 1 %h", k, bus_en, stallreq, m_rdata, mdl_rdata);
            end
            if (k == 4) begin bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF; end
        end
        @(negedge clk); bus_data_ok = 0; #1;
        checks++;
        if ({bus_en, stallreq, m_rdata} !== {1'b0, 1'b1, mdl_rdata}) begin
            errors++;
            $display("FAIL drain_after got en=%b stall=%b m_rdata=%h want 0 1 %h", bus_en, stallreq, m_rdata, mdl_rdata);
        end
        @(negedge clk); #1;
        checks++;
        if ({bus_en, bus_addr} !== {1'b1, va2}) begin
            errors++; $display("FAIL drain_req2 got en=%b addr=%h want 1 %h", bus_en, bus_addr, va2);
        end
        bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = rd2;
        @(negedge clk); bus_addr_ok = 0; bus_data_ok = 0; #1;
        mdl_rdata = rd2; mdl_vaddr = va2;
        checks++;
        if ({stallreq, m_rdata, m_vaddr} !== {1'b0, mdl_rdata, mdl_vaddr}) begin
            errors++;
            $display("FAIL drain_next got stall=%b m_rdata=%h m_vaddr=%h want 0 %h %h", stallreq, m_rdata, m_vaddr, mdl_rdata, mdl_vaddr);
        end
        adv = 1;
        @(negedge clk); adv = 0; op_valid = 0;
    endtask

    task automatic test_sc_nolink();
        do_op(OP_SC, 32'h0000_5000, 32'h0F0F_0F0F, 0, 0, 0, 0, 1);
        do_op(OP_SC, 32'h0000_5004, 32'h0F0F_0F0F, 1, 1, 1, $urandom, 0);
    endtask

    task automatic test_reset_in_resp();
        @(negedge clk);
        op_valid = 1; aluop = OP_LW; vaddr = 32'h0000_6004; flush = 0; adv = 0;
        @(negedge clk); bus_addr_ok = 1; bus_data_ok = 0;
        @(negedge clk); bus_addr_ok = 0; #1;
        checks++;
        if ({bus_en, stallreq} !== 2'b01) begin
            errors++; $display("FAIL resp_before_reset got en/stall=%b%b want 01", bus_en, stallreq);
        end
        resetn = 0; op_valid = 0; #1;
        check_all_zero("reset_in_resp");
        @(negedge clk); resetn = 1;
        mdl_rdata = 0; mdl_vaddr = 0;
        do_op(OP_LW, 32'h0000_6008, 0, 0, 0, 0, 32'h1357_9BDF, 0);
    endtask

    task automatic test_random();
        logic [7:0]  ops [15];
        logic [31:0] va;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_LWL, OP_LWR,
                OP_SB, OP_SH, OP_SW, OP_SC, OP_SWL, OP_SWR, OP_ADDU};
        for (int n = 0; n < 60; n++) begin
            va = $urandom;
            if ($urandom_range(0, 1) == 1) va[1:0] = 2'b00;
            do_op(ops[$urandom_range(0, 14)], va, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_align();
        test_misalign();
        test_latency();
        test_flush_req();
        test_flush_drain();
        test_sc_nolink();
        test_reset_in_resp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
